par2serial_8f: RTL and testbench

- Parallel-to-serial stage that consumes the 8-bit byte stream produced on the clk_8f domain and emits one bit per clk_8f cycle, MSB first.
- Inserts the idle/comma character whenever no data byte is ready, so the serial line is never undriven.
- Accepts bytes through a ready/valid handshake with a one-byte holding register.
- Sits directly downstream of the clock generator and byte-path logic, feeding the serial link.

---
 rtl/par2serial_8f.sv | 131 +++++++++++++
 tb/tb_par2serial_8f.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/par2serial_8f.sv
// par2serial_8f: MSB-first byte serializer on clk_8f with idle-character fill and a post-reset sync phase.
// Optional build macro P2S_KFLAG_EN adds the k_flag output marking inserted idle characters.
module par2serial_8f #(
    parameter logic [7:0]  IDLE_CHAR  = 8'hBC,
    parameter int unsigned SYNC_BYTES = 4
) (
    input  logic       clk_8f,
    input  logic       rst,
    input  logic       enb,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       byte_start,
`ifdef P2S_KFLAG_EN
    output logic       k_flag,
`endif
    output logic       synced
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned SYNC_W = 4;

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t              state_q;
    logic [SYNC_W-1:0]   sync_cnt_q;
    logic                synced_q;

    logic [CNT_W-1:0]    bit_cnt_q,    bit_cnt_d;
    logic [BYTE_W-1:0]   shift_q,      shift_d;
    logic [BYTE_W-1:0]   hold_q,       hold_d;
    logic                hold_full_q,  hold_full_d;
    logic                data_out_q,   data_out_d;
    logic                byte_start_q, byte_start_d;
    logic                idle_q,       idle_d;

    logic                boundary;
    logic                take;
    logic                accept;
    logic [BYTE_W-1:0]   next_byte;

    // Holding register is offered whenever empty; never while reset is applied.
    assign ready_out = ~rst & ~hold_full_q;
    assign accept    = valid_in & ready_out;

    assign boundary  = enb & (bit_cnt_q == '0);
    assign take      = boundary & (state_q == ST_ACTIVE) & hold_full_q;
    assign next_byte = take ? hold_q : IDLE_CHAR;

    // Next-state for the shifter and holding register.
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        byte_start_d = 1'b0;
        idle_d       = idle_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;

        if (enb) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (boundary) begin
                data_out_d   = next_byte[BYTE_W-1];
                shift_d      = {next_byte[BYTE_W-2:0], 1'b0};
                byte_start_d = 1'b1;
                idle_d       = ~take;
            end else begin
                data_out_d   = shift_q[BYTE_W-1];
                shift_d      = {shift_q[BYTE_W-2:0], 1'b0};
            end
        end

        // accept and take never coincide: take needs hold_full, accept needs it clear
        if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end
        if (take) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_8f) begin
        if (rst) begin
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            data_out_q   <= 1'b0;
            byte_start_q <= 1'b0;
            idle_q       <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            data_out_q   <= data_out_d;
            byte_start_q <= byte_start_d;
            idle_q       <= idle_d;
        end
    end

    // Sync phase: count completed idle bytes; idle_q is clear until the first byte has gone out.
    always_ff @(posedge clk_8f) begin
        if (rst) begin
            state_q    <= ST_SYNC;
            sync_cnt_q <= '0;
            synced_q   <= 1'b0;
        end else if (boundary && (state_q == ST_SYNC) && idle_q) begin
            sync_cnt_q <= sync_cnt_q + SYNC_W'(1);
            if ((sync_cnt_q + SYNC_W'(1)) == SYNC_W'(SYNC_BYTES)) begin
                state_q  <= ST_ACTIVE;
                synced_q <= 1'b1;
            end
        end
    end

    assign data_out   = data_out_q;
    assign byte_start = byte_start_q;
    assign synced     = synced_q;

`ifdef P2S_KFLAG_EN
    assign k_flag = idle_q;
`endif

endmodule

// File: tb/tb_par2serial_8f.sv
// tb_par2serial_8f: directed bench for par2serial_8f covering sync, data slots, streaming, enable stalls and reset.
module tb_par2serial_8f;

    logic       clk_8f = 1'b0;
    logic       rst;
    logic       enb;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       byte_start;
    logic       synced;
`ifdef P2S_KFLAG_EN
    logic       k_flag;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_8f = ~clk_8f;

    par2serial_8f dut (
        .clk_8f     (clk_8f),
        .rst        (rst),
        .enb        (enb),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .byte_start (byte_start),
`ifdef P2S_KFLAG_EN
        .k_flag     (k_flag),
`endif
        .synced     (synced)
    );

    task automatic tick();
        @(posedge clk_8f);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Runs n cycles from reset release; optionally offers 8'h3C on cycle 2 of the sync phase.
    task automatic run_sync(input int n, input bit offer);
        logic [7:0] idle;
        idle = 8'hBC;
        for (int k = 1; k <= n; k++) begin
            tick();
            chk("sync_data",   8'(data_out),   8'(idle[7 - ((k - 1) % 8)]));
            chk("sync_bstart", 8'(byte_start), 8'(((k - 1) % 8) == 0));
            chk("sync_synced", 8'(synced),     8'(k >= 33));
            chk("sync_ready",  8'(ready_out),  8'(!(offer && k >= 2)));
`ifdef P2S_KFLAG_EN
            chk("sync_kflag",  8'(k_flag),     8'd1);
`endif
            if (offer && k == 1) begin
                valid_in = 1'b1;
                data_in  = 8'h3C;
            end else if (offer && k == 2) begin
                valid_in = 1'b0;
            end
        end
    endtask

    initial begin
        logic [7:0]  a5;
        logic [7:0]  exp_seq [4];
        logic [7:0]  stream  [3];
        logic [7:0]  cur;
        logic [14:0] resume;
        logic [7:0]  b3c;
        logic        acc;
        int          idx;

        rst      = 1'b1;
        enb      = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;

        // Reset state
        repeat (3) tick();
        chk("rst_dout",   8'(data_out),   8'd0);
        chk("rst_bstart", 8'(byte_start), 8'd0);
        chk("rst_ready",  8'(ready_out),  8'd0);
        chk("rst_synced", 8'(synced),     8'd0);

        // Idle fill and sync: 40 cycles, synced at the 5th boundary (cycle 33)
        rst = 1'b0;
        enb = 1'b1;
        run_sync(40, 1'b0);

        // 8'hA5 accepted on boundary edge 41, sent in slot 49..56
        valid_in = 1'b1;
        data_in  = 8'hA5;
        tick();
        chk("a5_acc_ready",   8'(ready_out),  8'd0);
        chk("a5_idle_bstart", 8'(byte_start), 8'd1);
        chk("a5_idle_data",   8'(data_out),   8'd1);
        valid_in = 1'b0;
        for (int k = 42; k <= 48; k++) begin
            tick();
            chk("a5_wait_ready", 8'(ready_out), 8'd0);
        end
        a5 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("a5_data",   8'(data_out),   8'(a5[7 - i]));
            chk("a5_bstart", 8'(byte_start), 8'(i == 0));
            chk("a5_ready",  8'(ready_out),  8'd1);
`ifdef P2S_KFLAG_EN
            chk("a5_kflag",  8'(k_flag),     8'd0);
`endif
        end

        // Back-to-back stream 01, 80, FF with valid held high
        exp_seq[0] = 8'hBC;
        exp_seq[1] = 8'h01;
        exp_seq[2] = 8'h80;
        exp_seq[3] = 8'hFF;
        stream[0]  = 8'h01;
        stream[1]  = 8'h80;
        stream[2]  = 8'hFF;
        idx        = 0;
        valid_in   = 1'b1;
        data_in    = stream[0];
        for (int k = 57; k <= 88; k++) begin
            acc = ready_out && valid_in;
            tick();
            cur = exp_seq[(k - 57) / 8];
            chk("str_data",   8'(data_out),   8'(cur[7 - ((k - 57) % 8)]));
            chk("str_bstart", 8'(byte_start), 8'(((k - 57) % 8) == 0));
            chk("str_ready",  8'(ready_out),  8'(k == 65 || k == 73 || k >= 81));
            if (acc) begin
                idx++;
                if (idx < 3) data_in = stream[idx];
                else         valid_in = 1'b0;
            end
        end

        // Stall right after the boundary of an idle byte; offer 8'h5A while stalled
        tick();
        chk("pre_pause_data",   8'(data_out),   8'd1);
        chk("pre_pause_bstart", 8'(byte_start), 8'd1);
        enb = 1'b0;
        for (int p = 0; p < 5; p++) begin
            tick();
            chk("pause_data",   8'(data_out),   8'd1);
            chk("pause_bstart", 8'(byte_start), 8'd0);
            if (p == 0) begin
                valid_in = 1'b1;
                data_in  = 8'h5A;
            end else if (p == 1) begin
                chk("pause_ready", 8'(ready_out), 8'd0);
                valid_in = 1'b0;
            end
        end
        enb = 1'b1;
        // remaining idle bits 0111100, then 8'h5A
        resume = 15'b011110001011010;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("resume_data",   8'(data_out),   8'(resume[14 - i]));
            chk("resume_bstart", 8'(byte_start), 8'(i == 7));
        end

        // Reset at bit 3 of 8'h1F with 8'h66 held
        valid_in = 1'b1;
        data_in  = 8'h1F;
        tick();
        valid_in = 1'b0;
        repeat (7) tick();
        tick();
        chk("mid_bstart", 8'(byte_start), 8'd1);
        chk("mid_bit7",   8'(data_out),   8'd0);
        valid_in = 1'b1;
        data_in  = 8'h66;
        tick();
        valid_in = 1'b0;
        chk("mid_held_ready", 8'(ready_out), 8'd0);
        repeat (2) tick();
        chk("mid_bit4", 8'(data_out), 8'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_dout",   8'(data_out),   8'd0);
        chk("mid_rst_ready",  8'(ready_out),  8'd0);
        chk("mid_rst_synced", 8'(synced),     8'd0);
        chk("mid_rst_bstart", 8'(byte_start), 8'd0);
        rst = 1'b0;
        run_sync(41, 1'b0);

        // 8'h3C offered during sync is the first byte of the active phase
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        run_sync(40, 1'b1);
        b3c = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("sync3c_data",   8'(data_out),   8'(b3c[7 - i]));
            chk("sync3c_bstart", 8'(byte_start), 8'(i == 0));
            chk("sync3c_ready",  8'(ready_out),  8'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
